// File: rtl/ws2812_frame_scheduler.sv
// Double-buffered WS2812 frame store: the host fills the back bank, frames launch
// on bank swap or periodic refresh, and pixels are served on serializer READ_CK pulses.
module ws2812_frame_scheduler #(
    parameter int unsigned LED_NUM     = 16,
    parameter int unsigned ADDR_BIT    = $clog2(LED_NUM) + 1,
    parameter int unsigned REFRESH_CYC = 1666666
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                H_WE,
    input  logic [ADDR_BIT-1:0] H_ADDR,
    input  logic [23:0]         H_WDATA,
    input  logic [ADDR_BIT-1:0] H_LEN,
    input  logic                H_EN,
    input  logic                H_SWAP,
    output logic                H_SWAP_ACK,
    output logic                SWAP_PEND,
    input  logic                S_READY,
    input  logic                S_READ_CK,
    input  logic [ADDR_BIT-1:0] S_WNT,
    output logic [23:0]         S_RGB,
    output logic [ADDR_BIT-1:0] S_W_END,
    output logic                S_GO,
    output logic                BUSY,
    output logic [15:0]         FRAME_CNT
);
    localparam int unsigned IDX_W = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
    localparam int unsigned TMR_W = 32;
    localparam logic [ADDR_BIT-1:0] LED_MAX  = ADDR_BIT'(LED_NUM);
    localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(REFRESH_CYC - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE} state_t;

    state_t              state_q;
    state_t              state_d;
    logic [23:0]         bank [2][LED_NUM];
    logic                disp_bank;
    logic [TMR_W-1:0]    timer;
    logic                refresh_pend;
    logic                ck_prev;
    logic                phase;
    logic [ADDR_BIT-1:0] addr;

    logic do_swap;
    logic do_refresh;
    logic do_launch;
    logic do_start;
    logic do_done;
    logic ck_rise;
    logic tmr_wrap;

    assign ck_rise  = S_READ_CK & ~ck_prev;
    assign tmr_wrap = (timer == TMR_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Launches wait for an idle serializer, which also covers its post-reset frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (S_READY && (SWAP_PEND || refresh_pend)) state_d = LAUNCH;
            LAUNCH:     state_d = WAIT_START;
            WAIT_START: if (!S_READY) state_d = WAIT_DONE;
            WAIT_DONE:  if (S_READY) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        do_swap    = 1'b0;
        do_refresh = 1'b0;
        do_launch  = 1'b0;
        do_start   = 1'b0;
        do_done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (S_READY && SWAP_PEND)         do_swap    = 1'b1;
                else if (S_READY && refresh_pend) do_refresh = 1'b1;
            end
            LAUNCH:     do_launch = 1'b1;
            WAIT_START: do_start  = ~S_READY;
            WAIT_DONE:  do_done   = S_READY;
            default:    ;
        endcase
    end

    // Host writes always target the back bank; a write on the swap edge lands before it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bank <= '{default: '0};
        end else if (H_WE && (H_ADDR < LED_MAX)) begin
            bank[~disp_bank][H_ADDR[IDX_W-1:0]] <= H_WDATA;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            H_SWAP_ACK   <= 1'b0;
            SWAP_PEND    <= 1'b0;
            disp_bank    <= 1'b0;
            timer        <= '0;
            refresh_pend <= 1'b0;
            S_W_END      <= '0;
            S_GO         <= 1'b0;
            BUSY         <= 1'b0;
            FRAME_CNT    <= '0;
        end else begin
            H_SWAP_ACK <= do_swap;
            if (do_swap) begin
                disp_bank <= ~disp_bank;
                SWAP_PEND <= 1'b0;
            end else if (H_SWAP) begin
                SWAP_PEND <= 1'b1;
            end

            if (!H_EN) begin
                timer        <= '0;
                refresh_pend <= 1'b0;
            end else if (tmr_wrap) begin
                timer        <= '0;
                refresh_pend <= 1'b1;
            end else begin
                timer <= timer + TMR_W'(1);
                if (do_swap || do_refresh) refresh_pend <= 1'b0;
            end

            if (do_launch) begin
                S_W_END <= (H_LEN > LED_MAX) ? LED_MAX : H_LEN;
                BUSY    <= 1'b1;
                S_GO    <= 1'b1;
            end
            if (do_start) S_GO <= 1'b0;
            if (do_done) begin
                BUSY      <= 1'b0;
                FRAME_CNT <= FRAME_CNT + 16'd1;
            end
        end
    end

    // Two READ_CK rising edges per pixel: first latches the index, second fetches data.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ck_prev <= 1'b0;
            phase   <= 1'b0;
            addr    <= '0;
            S_RGB   <= '0;
        end else begin
            ck_prev <= S_READ_CK;
            if (do_launch) begin
                phase <= 1'b0;
            end else if (ck_rise) begin
                phase <= ~phase;
                if (!phase) addr <= S_WNT;
                else        S_RGB <= (addr < LED_MAX) ? bank[disp_bank][addr[IDX_W-1:0]] : 24'h0;
            end
        end
    end
endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Randomized bench for ws2812_frame_scheduler: serializer model, behavioural scheduler
// model compared every cycle, and literal expectations for the key scenarios.
module tb_ws2812_frame_scheduler;
    localparam int unsigned LED_NUM = 16;
    localparam int unsigned AB      = 5;
    localparam int unsigned RC      = 1000;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b1;
    logic          H_WE = 1'b0;
    logic [AB-1:0] H_ADDR = '0;
    logic [23:0]   H_WDATA = '0;
    logic [AB-1:0] H_LEN = 5'd16;
    logic          H_EN = 1'b0;
    logic          H_SWAP = 1'b0;
    logic          H_SWAP_ACK;
    logic          SWAP_PEND;
    logic          S_READY = 1'b0;
    logic          S_READ_CK = 1'b0;
    logic [AB-1:0] S_WNT = '0;
    logic [23:0]   S_RGB;
    logic [AB-1:0] S_W_END;
    logic          S_GO;
    logic          BUSY;
    logic [15:0]   FRAME_CNT;

    ws2812_frame_scheduler #(.LED_NUM(LED_NUM), .ADDR_BIT(AB), .REFRESH_CYC(RC)) dut (
        .CLK(CLK), .RST_N(RST_N), .H_WE(H_WE), .H_ADDR(H_ADDR), .H_WDATA(H_WDATA),
        .H_LEN(H_LEN), .H_EN(H_EN), .H_SWAP(H_SWAP), .H_SWAP_ACK(H_SWAP_ACK),
        .SWAP_PEND(SWAP_PEND), .S_READY(S_READY), .S_READ_CK(S_READ_CK), .S_WNT(S_WNT),
        .S_RGB(S_RGB), .S_W_END(S_W_END), .S_GO(S_GO), .BUSY(BUSY), .FRAME_CNT(FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural scheduler model: what the outputs must be, cycle by cycle.
    logic [23:0]   m_bank [2][LED_NUM];
    bit            m_disp, m_swp, m_ref, m_ack, m_go, m_busy, m_phase, m_prev;
    int unsigned   m_timer;
    int            m_mode;  // 0 waiting for work, 1 announcing, 2 handshake, 3 frame running
    int unsigned   m_cnt;
    int unsigned   m_wend;
    logic [AB-1:0] m_addr;
    logic [23:0]   m_rgb;

    task automatic model_reset();
        m_bank = '{default: '0};
        m_disp = 0; m_swp = 0; m_ref = 0; m_ack = 0; m_go = 0; m_busy = 0;
        m_phase = 0; m_prev = 0; m_timer = 0; m_mode = 0; m_cnt = 0; m_wend = 0;
        m_addr = '0; m_rgb = '0;
    endtask

    task automatic model_step();
        bit rise, swap_now, launch_now;
        rise   = S_READ_CK && !m_prev;
        m_prev = S_READ_CK;
        if (m_mode == 1) m_phase = 0;
        else if (rise) begin
            if (!m_phase) m_addr = S_WNT;
            else m_rgb = (m_addr < AB'(LED_NUM)) ? m_bank[m_disp][m_addr[3:0]] : 24'h0;
            m_phase = !m_phase;
        end
        if (H_WE && H_ADDR < AB'(LED_NUM)) m_bank[!m_disp][H_ADDR[3:0]] = H_WDATA;
        swap_now   = (m_mode == 0) && S_READY && m_swp;
        launch_now = (m_mode == 0) && S_READY && (m_swp || m_ref);
        m_ack = swap_now;
        if (swap_now) begin m_disp = !m_disp; m_swp = 0; end
        else if (H_SWAP) m_swp = 1;
        if (!H_EN) begin m_timer = 0; m_ref = 0; end
        else begin
            m_timer++;
            if (m_timer == RC) begin m_timer = 0; m_ref = 1; end
            else if (launch_now) m_ref = 0;
        end
        case (m_mode)
            0: if (launch_now) m_mode = 1;
            1: begin
                m_wend = (H_LEN > AB'(LED_NUM)) ? LED_NUM : 32'(H_LEN);
                m_busy = 1; m_go = 1; m_mode = 2;
            end
            2: if (!S_READY) begin m_go = 0; m_mode = 3; end
            default: if (S_READY) begin m_busy = 0; m_cnt = (m_cnt + 1) % 65536; m_mode = 0; end
        endcase
    endtask

    always begin
        @(posedge CLK or negedge RST_N);
        if (!RST_N) model_reset();
        else model_step();
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            check("S_GO", 32'(S_GO), 32'(m_go));
            check("BUSY", 32'(BUSY), 32'(m_busy));
            check("H_SWAP_ACK", 32'(H_SWAP_ACK), 32'(m_ack));
            check("SWAP_PEND", 32'(SWAP_PEND), 32'(m_swp));
            check("FRAME_CNT", 32'(FRAME_CNT), m_cnt);
            check("S_W_END", 32'(S_W_END), m_wend);
            check("S_RGB", 32'(S_RGB), 32'(m_rgb));
            check("ack_outside_busy", 32'(H_SWAP_ACK & BUSY), 32'd0);
        end
    end

    int cyc = 0;
    int go_times[$];
    bit go_prev = 1'b0;
    always @(posedge CLK) cyc++;
    always @(negedge CLK) begin
        if (S_GO && !go_prev) go_times.push_back(cyc);
        go_prev = S_GO;
    end

    // Serializer model with independent shadow banks; checks each fetched pixel.
    logic [23:0] sh_bank [2][LED_NUM];
    bit          sh_disp = 1'b0;
    logic [23:0] frame_img [LED_NUM];
    int          ser_st = 0, ser_cnt = 0, ser_pix = 0, ser_sub = 0;
    int          ser_wend = 0, ser_tail = 3, ser_tail_set = 3;
    logic [23:0] px3_seen = '0;

    initial sh_bank = '{default: '0};

    always begin
        @(posedge CLK);
        #1;
        if (!RST_N) begin
            ser_st = 0; ser_cnt = 0; S_READY = 1'b0; S_READ_CK = 1'b0; S_WNT = '0;
        end else begin
            if (H_SWAP_ACK) sh_disp = !sh_disp;
            case (ser_st)
                0: begin
                    S_READY = 1'b0;
                    ser_cnt++;
                    if (ser_cnt >= 5) begin S_READY = 1'b1; ser_st = 1; end
                end
                1: if (S_GO) begin
                    S_READY = 1'b0; ser_wend = 32'(S_W_END); ser_tail = ser_tail_set;
                    ser_pix = 0; ser_sub = 0; frame_img = sh_bank[sh_disp]; ser_st = 2;
                end
                2: if (ser_pix >= ser_wend) begin
                    ser_cnt = 0; ser_st = 3;
                end else begin
                    case (ser_sub)
                        0: begin S_WNT = AB'(ser_pix); S_READ_CK = 1'b1; end
                        2: S_READ_CK = 1'b1;
                        4: begin
                            check("pixel", 32'(S_RGB), 32'(frame_img[4'(ser_pix)]));
                            if (ser_pix == 3) px3_seen = S_RGB;
                        end
                        default: S_READ_CK = 1'b0;
                    endcase
                    if (ser_sub == 4) begin ser_sub = 0; ser_pix++; end
                    else ser_sub++;
                end
                default: begin
                    ser_cnt++;
                    if (ser_cnt >= ser_tail) begin S_READY = 1'b1; ser_st = 1; end
                end
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic write_px(input logic [AB-1:0] a, input logic [23:0] d);
        H_WE = 1'b1; H_ADDR = a; H_WDATA = d;
        if (a < AB'(LED_NUM)) sh_bank[!sh_disp][a[3:0]] = d;
        tick(1);
        H_WE = 1'b0;
    endtask

    task automatic rand_writes(input int n);
        for (int i = 0; i < n; i++) write_px(AB'($urandom_range(0, 31)), 24'($urandom));
    endtask

    task automatic pulse_swap();
        H_SWAP = 1'b1; tick(1); H_SWAP = 1'b0;
    endtask

    task automatic wait_cnt(input logic [15:0] target, input int budget);
        int n = 0;
        while (FRAME_CNT !== target && n < budget) begin tick(1); n++; end
        check("wait_frame_done", 32'(FRAME_CNT), 32'(target));
    endtask

    task automatic wait_busy(input int budget);
        int n = 0;
        while (BUSY !== 1'b1 && n < budget) begin tick(1); n++; end
        check("wait_busy", 32'(BUSY), 32'd1);
    endtask

    task automatic wait_go(input int budget);
        int n = 0;
        while (S_GO !== 1'b1 && n < budget) begin tick(1); n++; end
        check("wait_go", 32'(S_GO), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] cb;
        int n;
        #2 RST_N = 1'b0;
        #1 cmp_en = 1'b1;
        tick(3);
        check("reset_S_GO", 32'(S_GO), 32'd0);
        check("reset_BUSY", 32'(BUSY), 32'd0);
        check("reset_FRAME_CNT", 32'(FRAME_CNT), 32'd0);
        check("reset_S_RGB", 32'(S_RGB), 32'd0);
        RST_N = 1'b1;

        // First swap after reset: pixel 3 must reach the serializer.
        rand_writes(6);
        write_px(5'd3, 24'h112233);
        pulse_swap();
        n = 0;
        while (H_SWAP_ACK !== 1'b1 && n < 50) begin tick(1); n++; end
        check("swap_ack", 32'(H_SWAP_ACK), 32'd1);
        tick(1);
        check("first_go", 32'(S_GO), 32'd1);
        check("first_w_end", 32'(S_W_END), 32'd16);
        wait_cnt(16'd1, 300);
        check("pixel3_value", 32'(px3_seen), 32'h112233);

        // Periodic refresh, display bank unchanged.
        cb = FRAME_CNT;
        go_times.delete();
        H_EN = 1'b1;
        tick(3600);
        H_EN = 1'b0;
        check("refresh_frames", 32'(go_times.size()), 32'd3);
        for (int i = 1; i < go_times.size(); i++)
            check("refresh_period", 32'(go_times[i] - go_times[i-1]), 32'd1000);
        wait_cnt(cb + 16'(go_times.size()), 400);

        // Swap requested mid-frame stays pending until the frame ends.
        for (int i = 0; i < 16; i++) write_px(AB'(i), 24'($urandom));
        pulse_swap();
        wait_busy(50);
        cb = FRAME_CNT;
        tick(20);
        rand_writes(4);
        pulse_swap();
        check("pend_mid_frame", 32'(SWAP_PEND), 32'd1);
        check("busy_mid_frame", 32'(BUSY), 32'd1);
        wait_cnt(cb + 16'd1, 300);
        wait_cnt(cb + 16'd2, 300);

        // Swap and refresh pending together produce exactly one frame.
        ser_tail_set = 1500;
        H_EN = 1'b1;
        pulse_swap();
        wait_busy(50);
        tick(5);
        ser_tail_set = 3;
        tick(100);
        pulse_swap();
        cb = FRAME_CNT;
        wait_cnt(cb + 16'd1, 2000);
        go_times.delete();
        tick(300);
        check("single_launch", 32'(go_times.size()), 32'd1);
        check("pend_cleared", 32'(SWAP_PEND), 32'd0);
        H_EN = 1'b0;
        wait_cnt(cb + 16'd2, 300);

        // Frame length clamping, zero-length frame and random lengths.
        H_LEN = 5'd20;
        pulse_swap();
        wait_go(20);
        check("w_end_clamp20", 32'(S_W_END), 32'd16);
        wait_cnt(FRAME_CNT + 16'd1, 300);
        H_LEN = 5'd0;
        cb = FRAME_CNT;
        pulse_swap();
        wait_go(20);
        check("w_end_zero", 32'(S_W_END), 32'd0);
        wait_cnt(cb + 16'd1, 100);
        for (int k = 0; k < 4; k++) begin
            H_LEN = AB'($urandom_range(0, 31));
            rand_writes(8);
            cb = FRAME_CNT;
            pulse_swap();
            wait_go(20);
            check("w_end_rand", 32'(S_W_END), (H_LEN > 5'd16) ? 32'd16 : 32'(H_LEN));
            wait_cnt(cb + 16'd1, 300);
        end

        // Reset while a frame is in flight.
        H_LEN = 5'd16;
        rand_writes(6);
        pulse_swap();
        wait_busy(50);
        tick(30);
        check("busy_before_reset", 32'(BUSY), 32'd1);
        RST_N = 1'b0;
        #1;
        check("midreset_S_GO", 32'(S_GO), 32'd0);
        check("midreset_BUSY", 32'(BUSY), 32'd0);
        check("midreset_S_RGB", 32'(S_RGB), 32'd0);
        check("midreset_FRAME_CNT", 32'(FRAME_CNT), 32'd0);
        sh_bank = '{default: '0};
        sh_disp = 1'b0;
        tick(3);
        RST_N = 1'b1;
        go_times.delete();
        pulse_swap();
        tick(2);
        check("no_go_during_boot", 32'(go_times.size()), 32'd0);
        check("pend_during_boot", 32'(SWAP_PEND), 32'd1);
        wait_cnt(16'd1, 300);

        tick(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
